// File: rtl/array_ctrl_eyeriss_pkg.sv
// Shared types and default geometry for the systolic-array control sequencer.
package array_ctrl_pkg;
    localparam int DEF_HEIGHT = 12;
    localparam int DEF_WIDTH  = 14;
    localparam int DEF_CWIDTH = 8;
    localparam int DEF_VWIDTH = 16;

    typedef enum logic [2:0] {
        IDLE, WLOAD, COMP, FLUSH, OUT, DONE
    } state_e;
endpackage

// File: rtl/array_ctrl_eyeriss_if.sv
// Job request and array strobe bundle between the sequencer and its users.
interface array_ctrl_eyeriss_if import array_ctrl_pkg::*; #(
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CWIDTH = DEF_CWIDTH,
    parameter int VWIDTH = DEF_VWIDTH
);
    logic              start;
    logic [CWIDTH-1:0] mac_cycles;
    logic [VWIDTH-1:0] num_vec;
    logic [HEIGHT-1:0] en_i, clr_i, mac_done;
    logic [WIDTH-1:0]  en_w, clr_w, en_o, clr_o;
    logic              ifm_rd, wght_rd, busy, done;

    modport master (
        output start, mac_cycles, num_vec,
        input  en_i, clr_i, mac_done, en_w, clr_w, en_o, clr_o,
        input  ifm_rd, wght_rd, busy, done
    );
    modport slave (
        input  start, mac_cycles, num_vec,
        output en_i, clr_i, mac_done, en_w, clr_w, en_o, clr_o,
        output ifm_rd, wght_rd, busy, done
    );
endinterface

// File: rtl/array_ctrl_eyeriss_skew_dly.sv
// Per-lane delay line of DEPTH cycles (DEPTH >= 1) carrying a W-bit strobe bundle.
module skew_dly #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [DEPTH-1:0][W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d[0] = d;
        for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/array_ctrl_eyeriss.sv
// Row/column strobe sequencer for the rate-coded systolic array.
// Define ARRAY_CTRL_SKEW_EN for the FLUSH phase and per-row/per-column skew delays.
module array_ctrl_eyeriss import array_ctrl_pkg::*; #(
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CWIDTH = DEF_CWIDTH,
    parameter int VWIDTH = DEF_VWIDTH
) (
    input logic                 clk,
    input logic                 rst,
    array_ctrl_eyeriss_if.slave bus
);
    localparam int LW = $clog2(HEIGHT + WIDTH) + 1;
    localparam int PW = (CWIDTH > LW) ? CWIDTH : LW;
`ifdef ARRAY_CTRL_SKEW_EN
    localparam int OUT_LEN = HEIGHT + WIDTH - 1;
`else
    localparam int OUT_LEN = HEIGHT;
`endif

    state_e            state_q, state_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [VWIDTH-1:0] vec_q, vec_d, nv_q, nv_d;
    logic [CWIDTH-1:0] mac_q, mac_d;
    // row bundle {mac_done, clr_i, en_i}; column bundle {clr_o, en_o, clr_w, en_w}
    logic [2:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic              ifm_q, ifm_d, wght_q, wght_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + PW'(1);
        vec_d   = vec_q;
        mac_d   = mac_q;
        nv_d    = nv_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    mac_d   = bus.mac_cycles;
                    nv_d    = bus.num_vec;
                    vec_d   = '0;
                    state_d = (bus.mac_cycles == '0 || bus.num_vec == '0) ? DONE : WLOAD;
                end
            end
            WLOAD: if (cnt_q == PW'(HEIGHT - 1)) begin
                state_d = COMP;
                cnt_d   = '0;
            end
            COMP: if (cnt_q == PW'(mac_q) - PW'(1)) begin
                cnt_d = '0;
`ifdef ARRAY_CTRL_SKEW_EN
                state_d = FLUSH;
`else
                state_d = OUT;
`endif
            end
            FLUSH: if (cnt_q == PW'(HEIGHT - 2)) begin
                state_d = OUT;
                cnt_d   = '0;
            end
            OUT: if (cnt_q == PW'(OUT_LEN - 1)) begin
                cnt_d = '0;
                if (vec_q == nv_q - VWIDTH'(1)) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + VWIDTH'(1);
                    state_d = COMP;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // Strobes decode the next state so they are registered alongside it.
        row_d[0] = (state_d == COMP);
        row_d[1] = (state_d == COMP) && (cnt_d == '0);
        row_d[2] = (state_d == COMP) && (cnt_d == PW'(mac_d) - PW'(1));
        col_d[0] = (state_d == WLOAD);
        col_d[1] = (state_d == WLOAD) && (cnt_d == '0);
        col_d[2] = (state_d == OUT) && (cnt_d < PW'(HEIGHT));
        col_d[3] = (state_d == OUT) && (cnt_d == PW'(HEIGHT - 1));
        ifm_d    = row_d[1];
        wght_d   = col_d[0];
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            mac_q   <= '0;
            nv_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ifm_q   <= 1'b0;
            wght_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            mac_q   <= mac_d;
            nv_q    <= nv_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ifm_q   <= ifm_d;
            wght_q  <= wght_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    logic [HEIGHT-1:0] en_i_w, clr_i_w, mdone_w;
    logic [WIDTH-1:0]  en_w_w, clr_w_w, en_o_w, clr_o_w;

`ifdef ARRAY_CTRL_SKEW_EN
    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        logic [2:0] r;
        if (h == 0) begin : g_direct
            assign r = row_q;
        end else begin : g_dly
            skew_dly #(.DEPTH(h), .W(3)) u_dly (.clk(clk), .rst(rst), .d(row_q), .q(r));
        end
        assign en_i_w[h]  = r[0];
        assign clr_i_w[h] = r[1];
        assign mdone_w[h] = r[2];
    end
    for (genvar w = 0; w < WIDTH; w++) begin : g_col
        logic [3:0] c;
        if (w == 0) begin : g_direct
            assign c = col_q;
        end else begin : g_dly
            skew_dly #(.DEPTH(w), .W(4)) u_dly (.clk(clk), .rst(rst), .d(col_q), .q(c));
        end
        assign en_w_w[w]  = c[0];
        assign clr_w_w[w] = c[1];
        assign en_o_w[w]  = c[2];
        assign clr_o_w[w] = c[3];
    end
`else
    assign en_i_w  = {HEIGHT{row_q[0]}};
    assign clr_i_w = {HEIGHT{row_q[1]}};
    assign mdone_w = {HEIGHT{row_q[2]}};
    assign en_w_w  = {WIDTH{col_q[0]}};
    assign clr_w_w = {WIDTH{col_q[1]}};
    assign en_o_w  = {WIDTH{col_q[2]}};
    assign clr_o_w = {WIDTH{col_q[3]}};
`endif

    assign bus.en_i     = en_i_w;
    assign bus.clr_i    = clr_i_w;
    assign bus.mac_done = mdone_w;
    assign bus.en_w     = en_w_w;
    assign bus.clr_w    = clr_w_w;
    assign bus.en_o     = en_o_w;
    assign bus.clr_o    = clr_o_w;
    assign bus.ifm_rd   = ifm_q;
    assign bus.wght_rd  = wght_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_array_ctrl_eyeriss.sv
// Directed bench for array_ctrl_eyeriss; expectations follow the ARRAY_CTRL_SKEW_EN setting.
module tb_array_ctrl_eyeriss;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    array_ctrl_eyeriss_if bus ();
    array_ctrl_eyeriss dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef ARRAY_CTRL_SKEW_EN
    localparam int A_DONE = 124, A_ALL = 0;
    localparam int B_DONE = 93, B_ENI5 = 18, B_MD11 = 27;
`else
    localparam int A_DONE = 52, A_ALL = 3;
    localparam int B_DONE = 45, B_ENI5 = 13, B_MD11 = 16;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int n_done, done_cnt, all_cnt, eni0_cnt, wght_cnt, clrw_cnt, eno_cnt, clro_cnt, ifm_cnt, act_cnt;
    int t_eni0, t_eni5, t_md0, t_md11;
    logic busy_after, done_after;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] all_out();
        return {bus.busy, bus.done, bus.ifm_rd, bus.wght_rd, bus.en_i, bus.clr_i, bus.mac_done,
                bus.en_w, bus.clr_w, bus.en_o, bus.clr_o};
    endfunction

    // Launch one job, then watch outputs #1 after each edge; n counts edges from the sampling edge.
    task automatic run_job(input logic [7:0] mac, input logic [15:0] nv, input int inject_at);
        n_done = 0; done_cnt = 0; all_cnt = 0; eni0_cnt = 0; wght_cnt = 0; clrw_cnt = 0;
        eno_cnt = 0; clro_cnt = 0; ifm_cnt = 0; act_cnt = 0;
        t_eni0 = 0; t_eni5 = 0; t_md0 = 0; t_md11 = 0;
        busy_after = 1'bx; done_after = 1'bx;
        @(negedge clk);
        bus.start = 1'b1; bus.mac_cycles = mac; bus.num_vec = nv;
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk); #1;
            if (n_done != 0) begin
                busy_after = bus.busy;
                done_after = bus.done;
                break;
            end
            if (n == 1) begin
                bus.start = 1'b0; bus.mac_cycles = '0; bus.num_vec = '0;
            end
            if (n == inject_at) begin
                bus.start = 1'b1; bus.mac_cycles = 8'd9; bus.num_vec = 16'd5;
            end
            if (n == inject_at + 1) bus.start = 1'b0;
            if (&bus.en_i && &bus.clr_i && &bus.mac_done) all_cnt++;
            if (bus.en_i[0]) eni0_cnt++;
            if (bus.wght_rd) wght_cnt++;
            if (bus.clr_w[0]) clrw_cnt++;
            if (bus.en_o[0]) eno_cnt++;
            if (bus.clr_o[0]) clro_cnt++;
            if (bus.ifm_rd) ifm_cnt++;
            if (|{bus.ifm_rd, bus.wght_rd, bus.en_i, bus.clr_i, bus.mac_done,
                  bus.en_w, bus.clr_w, bus.en_o, bus.clr_o}) act_cnt++;
            if (bus.en_i[0] && t_eni0 == 0) t_eni0 = n;
            if (bus.en_i[5] && t_eni5 == 0) t_eni5 = n;
            if (bus.mac_done[0] && t_md0 == 0) t_md0 = n;
            if (bus.mac_done[11] && t_md11 == 0) t_md11 = n;
            if (bus.done) begin
                done_cnt++;
                n_done = n;
            end
        end
    endtask

    initial begin
        logic seen;
        rst = 1'b1; bus.start = 1'b0; bus.mac_cycles = '0; bus.num_vec = '0;
        #12;
        chk("reset_outs", all_out(), '0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_outs", all_out(), '0);

        // Zero-length jobs finish immediately with no strobe activity.
        run_job(8'd0, 16'd2, 0);
        chk("zmac_done_n", 96'(n_done), 96'd1);
        chk("zmac_act", 96'(act_cnt), 96'd0);
        chk("zmac_idle_after", {95'd0, busy_after}, 96'd0);
        run_job(8'd3, 16'd0, 0);
        chk("znv_done_n", 96'(n_done), 96'd1);
        chk("znv_act", 96'(act_cnt), 96'd0);
        chk("znv_done_cnt", 96'(done_cnt), 96'd1);

        // Single-cycle MAC window, three vectors.
        run_job(8'd1, 16'd3, 0);
        chk("a_done_n", 96'(n_done), 96'(A_DONE));
        chk("a_all_ones", 96'(all_cnt), 96'(A_ALL));
        chk("a_eni0_cnt", 96'(eni0_cnt), 96'd3);
        chk("a_wght_cnt", 96'(wght_cnt), 96'd12);
        chk("a_clrw_cnt", 96'(clrw_cnt), 96'd1);
        chk("a_eno_cnt", 96'(eno_cnt), 96'd36);
        chk("a_clro_cnt", 96'(clro_cnt), 96'd3);
        chk("a_ifm_cnt", 96'(ifm_cnt), 96'd3);
        chk("a_done_after", {94'd0, busy_after, done_after}, 96'd0);

        // Four-cycle MAC window, two vectors: latency and row skew.
        run_job(8'd4, 16'd2, 0);
        chk("b_done_n", 96'(n_done), 96'(B_DONE));
        chk("b_eni0_t", 96'(t_eni0), 96'd13);
        chk("b_eni5_t", 96'(t_eni5), 96'(B_ENI5));
        chk("b_md0_t", 96'(t_md0), 96'd16);
        chk("b_md11_t", 96'(t_md11), 96'(B_MD11));
        chk("b_eni0_cnt", 96'(eni0_cnt), 96'd8);
        chk("b_eno_cnt", 96'(eno_cnt), 96'd24);

        // A second start during the job must not disturb it.
        run_job(8'd4, 16'd2, 20);
        chk("busy_start_done_n", 96'(n_done), 96'(B_DONE));
        chk("busy_start_done_cnt", 96'(done_cnt), 96'd1);
        chk("busy_start_eni0_cnt", 96'(eni0_cnt), 96'd8);
        chk("busy_start_idle_after", {95'd0, busy_after}, 96'd0);

        // Reset asserted mid-COMP clears everything at once.
        @(negedge clk);
        bus.start = 1'b1; bus.mac_cycles = 8'd4; bus.num_vec = 16'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.en_i[0]) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("mid_comp_reached", {95'd0, seen}, 96'd1);
        #2 rst = 1'b1;
        #1 chk("mid_rst_outs", all_out(), '0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("after_mid_rst_outs", all_out(), '0);
        run_job(8'd4, 16'd2, 0);
        chk("rerun_done_n", 96'(n_done), 96'(B_DONE));
        chk("rerun_eni0_cnt", 96'(eni0_cnt), 96'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/array_ctrl_eyeriss.md
ARRAY_CTRL_EYERISS -- requirements
Module: array_ctrl_eyeriss

Upstream sequencer that drives the row and column control strobes of the 12x14 rate-coded systolic array.

Interface
REQ-001 SHALL have parameter HEIGHT, default 12, giving the number of array rows.
REQ-002 SHALL have parameter WIDTH, default 14, giving the number of array columns.
REQ-003 SHALL have parameter CWIDTH, default 8, giving the width of the MAC-cycle count (rate-coded bitstream length).
REQ-004 SHALL have parameter VWIDTH, default 16, giving the width of the vector count.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-008 SHALL have port mac_cycles, input, CWIDTH bits: cycles per MAC window, latched on start.
REQ-009 SHALL have port num_vec, input, VWIDTH bits: ifm vectors per weight tile, latched on start.
REQ-010 SHALL have ports en_i, clr_i and mac_done, each output, HEIGHT bits: row-entry strobes.
REQ-011 SHALL have ports en_w and clr_w, each output, WIDTH bits: column weight-load strobes.
REQ-012 SHALL have ports en_o and clr_o, each output, WIDTH bits: column output-drain strobes.
REQ-013 SHALL have ports ifm_rd and wght_rd, each output, 1 bit: read requests to the ifm and weight buffers.
REQ-014 SHALL have ports busy and done, each output, 1 bit: job status; done is a 1-cycle pulse.

Function
REQ-015 SHALL implement the FSM states IDLE, WLOAD, COMP, FLUSH, OUT and DONE.
REQ-016 IDLE with start=1 SHALL go to DONE if mac_cycles==0 or num_vec==0; otherwise it SHALL go to WLOAD.
REQ-017 WLOAD SHALL last HEIGHT cycles with wght_rd=1 and en_w all ones; clr_w SHALL be all ones on the first WLOAD cycle only.
REQ-018 COMP SHALL last mac_cycles cycles with base en_i=1; base clr_i and ifm_rd SHALL be asserted on the first cycle, and base mac_done on the last cycle.
REQ-019 FLUSH SHALL last HEIGHT-1 cycles with all strobes deasserted.
REQ-020 OUT SHALL last HEIGHT+WIDTH-1 cycles; base en_o SHALL be 1 for the first HEIGHT cycles, and base clr_o SHALL be asserted on cycle HEIGHT-1 of OUT.
REQ-021 After OUT, the FSM SHALL go to DONE if vec_cnt==num_vec-1; otherwise it SHALL increment vec_cnt and go to COMP.
REQ-022 DONE SHALL pulse done=1 for one cycle and then go to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 The row-h copy of each row base strobe SHALL be delayed by h cycles; the column-w copy of each column base strobe SHALL be delayed by w cycles.
REQ-026 Counters SHALL be unsigned.
REQ-027 mac_cycles=1 SHALL assert clr_i, en_i and mac_done in the same cycle.
REQ-028 mac_cycles and num_vec changes SHALL have no effect while busy=1.

Reset
REQ-029 rst SHALL asynchronously force the state to IDLE and clear all counters, latched configuration and skew registers.
REQ-030 During and immediately after reset, every output SHALL be 0, including after a reset asserted mid-job.

Configuration
REQ-031 With macro ARRAY_CTRL_SKEW_EN defined, the FSM SHALL include FLUSH and the per-row/per-column skew delays of REQ-025.
REQ-032 Without ARRAY_CTRL_SKEW_EN, all rows and columns SHALL receive identical undelayed strobes, FLUSH SHALL be skipped (COMP goes directly to OUT), and OUT SHALL last HEIGHT cycles.

Structure
REQ-033 Package array_ctrl_pkg SHALL hold the state enum and the default HEIGHT, WIDTH, CWIDTH and VWIDTH constants.
REQ-034 Sub-module skew_dly SHALL provide a parameterised per-lane shift register (DEPTH, reset to 0); it SHALL be instantiated per row and per column only when ARRAY_CTRL_SKEW_EN is defined.

Verification
REQ-035 Reset mid-COMP SHALL be checked: all outputs 0 in the next cycle, busy=0, then a new start runs correctly.
REQ-036 HEIGHT=12, WIDTH=14, mac_cycles=4, num_vec=2, skew on: done SHALL pulse 93 cycles after start is sampled (WLOAD 12 + 2 vectors x (COMP 4 + FLUSH 11 + OUT 25) + DONE 1).
REQ-037 Same job with skew on: en_i[5] rises exactly 5 cycles after en_i[0]; mac_done[11] SHALL pulse 11 cycles after mac_done[0].
REQ-038 mac_cycles=0 or num_vec=0 SHALL produce a done pulse in the cycle after start, with no en_*, clr_*, ifm_rd or wght_rd activity.
REQ-039 start asserted while busy=1 SHALL be ignored, and the job in progress completes unchanged.
REQ-040 Skew off, mac_cycles=1, num_vec=3: en_i, clr_i and mac_done SHALL be all ones simultaneously for 1 cycle per vector, and done SHALL pulse 12+3x13+1=52 cycles after start is sampled.
